tile_compute_ctrl: RTL and testbench
====================================

TILE_COMPUTE_CTRL -- requirements
Module: tile_compute_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 16, row-count width; ADDR_WIDTH, 16, address width; SYS_ROW, 16, systolic rows = weight rows per tile; MAX_TILES, 8, max weight tiles per job; TW = $clog2(MAX_TILES+1) (localparam).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock; one clock domain.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  job request pulse.
- num_row_in  in  DATA_WIDTH  input rows per tile.
- num_tile_in  in  TW  weight tiles in job.
- acc_base_in  in  ADDR_WIDTH  accumulator base address.
- drain_done  in  1  weight FIFO fill complete.
- sys_done  in  1  systolic pass complete.
- sys_en_out  in  1  valid psum row from array.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- fifo_in_ctrl_en, fifo_out_ctrl_en  out  1 each  weight-fill launch pulses.
- mem_rd_ctrl_en  out  1  input-read launch pulse.
- w_offset_addr  out  ADDR_WIDTH  weight source offset for the current fill.
- accum_wr_addr  out  ADDR_WIDTH  accumulator write address.
- accum_acc  out  1  0 = overwrite (tile 0), 1 = accumulate.
- tile_idx  out  TW  tile currently computing.
- perf_cycles  out  32  busy-cycle count (see Configuration).

Function
REQ-003 All outputs SHALL be registered; each reacts one cycle after its causing input/state condition.
REQ-004 States SHALL be IDLE, W_FILL, COMPUTE, WAIT_W, DONE.
REQ-005 IDLE: on start, latch num_row_in, num_tile_in, acc_base_in; tile_idx := 0; if num_tile_in == 0 or num_row_in == 0 -> DONE with no enable pulses; else pulse both fifo enables with w_offset_addr = 0 -> W_FILL.
REQ-006 start SHALL be ignored outside IDLE; latched job values SHALL not change mid-job.
REQ-007 W_FILL: on drain_done, pulse mem_rd_ctrl_en -> COMPUTE; if tile_idx+1 < tiles, pulse both fifo enables simultaneously with w_offset_addr = (tile_idx+1)*SYS_ROW (prefetch into shadow buffer).
REQ-008 drain_done arriving during COMPUTE SHALL be captured in a sticky prefetch_ready flag, cleared on entry to COMPUTE.
REQ-009 COMPUTE on sys_done: last tile -> DONE; otherwise tile_idx += 1 and -> WAIT_W.
REQ-010 WAIT_W: if prefetch_ready or drain_done, pulse mem_rd_ctrl_en (and the next prefetch per REQ-007) -> COMPUTE; otherwise hold.
REQ-011 DONE: done = 1 for exactly one cycle -> IDLE; busy = 1 in every state except IDLE.
REQ-012 w_offset_addr SHALL be 0 in every cycle without a fill pulse; arithmetic truncates to ADDR_WIDTH.
REQ-013 Row counter: 0 at job/tile start; +1 per sys_en_out cycle; wraps to 0 after num_row-1; accum_wr_addr = acc_base + counter, modulo 2^ADDR_WIDTH.
REQ-014 accum_acc SHALL be 0 while tile_idx == 0, else 1.
REQ-015 sys_en_out outside COMPUTE SHALL be ignored (counter holds 0).

Reset
REQ-016 While rstn = 0 at a clk edge: state = IDLE; all outputs, counters, latched values and prefetch_ready = 0; reset mid-job SHALL abort with no done pulse.

Configuration
REQ-017 Macro TILE_COMPUTE_CTRL_PERF_EN defined: perf_cycles clears on accepted start and increments each busy cycle, saturating at 2^32-1; undefined: perf_cycles is tied to 0 and no counter logic exists.

Structure
REQ-018 State enum, TW computation and default widths SHALL live in neurex_ctrl_pkg.
REQ-019 Row counter/address logic SHALL be sub-module accum_addr_gen (ports: clk, rstn, clr, inc, num_row, base, addr).

Verification
REQ-020 Single tile, num_row=4, base=0x10: start -> fifo pulses; drain_done -> mem_rd pulse; 4 sys_en_out -> addrs 0x10..0x13, accum_acc=0; sys_done -> done pulse after 2 cycles.
REQ-021 Three tiles, SYS_ROW=16: fill offsets 0, 16, 32; accum_acc=1 for tiles 1-2; exactly 3 mem_rd pulses and 1 done.
REQ-022 Prefetch drain_done during COMPUTE: WAIT_W lasts 1 cycle; drain_done late by 5 cycles: WAIT_W holds 5 cycles, then mem_rd.
REQ-023 num_tile_in=0 or num_row_in=0: done 2 cycles after start, no enable pulses; start while busy ignored.
REQ-024 rstn low during COMPUTE of tile 1: all outputs 0 next cycle, no done; new job runs cleanly afterward.
REQ-025 PERF_EN on: 3-tile job perf_cycles equals busy-high cycle count; PERF_EN off: perf_cycles stays 0.

Source files
------------

// File: rtl/neurex_ctrl_pkg.sv
// Shared types and defaults for the tile compute controller: FSM state
// encoding, default parameter widths and the tile-index width helper.
package neurex_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_SYS_ROW    = 16;
  localparam int DEF_MAX_TILES  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_FILL,
    S_COMPUTE,
    S_WAIT_W,
    S_DONE
  } ctrl_state_t;

  // Width of a tile count/index able to hold 0..max_tiles.
  function automatic int calc_tw(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

endpackage

// File: rtl/accum_addr_gen.sv
// Accumulator row counter and write-address generator.
// The counter steps once per valid psum row and wraps after num_row-1.
// base is the value the job base address will hold in the following cycle,
// so addr always equals base + counter without an extra cycle of lag.
module accum_addr_gen
  import neurex_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cnt_d;

  // Next row count: clear wins, otherwise step with wrap at num_row-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == num_row - DATA_WIDTH'(1)) ? '0 : cnt_q + DATA_WIDTH'(1);
    end
  end

  // Counter and registered address, modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      cnt_q <= '0;
      addr  <= '0;
    end else begin
      cnt_q <= cnt_d;
      addr  <= base + ADDR_WIDTH'(cnt_d);
    end
  end

endmodule

// File: rtl/tile_compute_ctrl.sv
// Tile compute controller: sequences weight-tile fills (with one-tile
// prefetch into the shadow buffer), input reads and systolic passes for a
// multi-tile job, and generates accumulator write addresses.
// Optional build macro TILE_COMPUTE_CTRL_PERF_EN enables the busy-cycle
// counter on perf_cycles; without it perf_cycles is constant 0.
module tile_compute_ctrl
  import neurex_ctrl_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int  SYS_ROW    = DEF_SYS_ROW,
  parameter int  MAX_TILES  = DEF_MAX_TILES,
  localparam int TW         = calc_tw(MAX_TILES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num_row_in,
  input  logic [TW-1:0]         num_tile_in,
  input  logic [ADDR_WIDTH-1:0] acc_base_in,
  input  logic                  drain_done,
  input  logic                  sys_done,
  input  logic                  sys_en_out,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_in_ctrl_en,
  output logic                  fifo_out_ctrl_en,
  output logic                  mem_rd_ctrl_en,
  output logic [ADDR_WIDTH-1:0] w_offset_addr,
  output logic [ADDR_WIDTH-1:0] accum_wr_addr,
  output logic                  accum_acc,
  output logic [TW-1:0]         tile_idx,
  output logic [31:0]           perf_cycles
);

  ctrl_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] num_row_q, num_row_d;
  logic [TW-1:0]         num_tile_q, num_tile_d;
  logic [ADDR_WIDTH-1:0] acc_base_q, acc_base_d;
  logic [TW-1:0]         tile_idx_d;
  logic                  prefetch_q, prefetch_d;
  logic                  fill_d;
  logic                  mem_rd_d;
  logic [ADDR_WIDTH-1:0] w_offset_d;
  logic                  start_ok;
  logic                  last_tile;
  logic [ADDR_WIDTH-1:0] next_fill_off;
  logic                  cnt_clr;
  logic                  cnt_inc;

  // The tile after the current one is the prefetch target.
  assign last_tile     = (tile_idx + TW'(1)) >= num_tile_q;
  assign next_fill_off = (ADDR_WIDTH'(tile_idx) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(SYS_ROW);

  // Next state, job latches and next values of the pulse outputs.
  always_comb begin
    state_d    = state_q;
    num_row_d  = num_row_q;
    num_tile_d = num_tile_q;
    acc_base_d = acc_base_q;
    tile_idx_d = tile_idx;
    prefetch_d = prefetch_q;
    fill_d     = 1'b0;
    mem_rd_d   = 1'b0;
    w_offset_d = '0;
    start_ok   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          num_row_d  = num_row_in;
          num_tile_d = num_tile_in;
          acc_base_d = acc_base_in;
          tile_idx_d = '0;
          if (num_tile_in == '0 || num_row_in == '0) begin
            state_d = S_DONE;
          end else begin
            fill_d  = 1'b1;
            state_d = S_W_FILL;
          end
        end
      end
      S_W_FILL: begin
        if (drain_done) begin
          mem_rd_d = 1'b1;
          state_d  = S_COMPUTE;
          if (!last_tile) begin
            fill_d     = 1'b1;
            w_offset_d = next_fill_off;
          end
        end
      end
      S_COMPUTE: begin
        // A prefetch fill finishing mid-pass is remembered for WAIT_W.
        if (drain_done) prefetch_d = 1'b1;
        if (sys_done) begin
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            tile_idx_d = tile_idx + TW'(1);
            state_d    = S_WAIT_W;
          end
        end
      end
      S_WAIT_W: begin
        if (prefetch_q || drain_done) begin
          mem_rd_d = 1'b1;
          state_d  = S_COMPUTE;
          if (!last_tile) begin
            fill_d     = 1'b1;
            w_offset_d = next_fill_off;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_COMPUTE && state_q != S_COMPUTE) prefetch_d = 1'b0;
  end

  // Row counter only runs while staying in COMPUTE; it is held at 0 elsewhere.
  assign cnt_clr = (state_q != S_COMPUTE) || (state_d != S_COMPUTE);
  assign cnt_inc = sys_en_out && !cnt_clr;

  // State, job latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      num_row_q        <= '0;
      num_tile_q       <= '0;
      acc_base_q       <= '0;
      prefetch_q       <= 1'b0;
      tile_idx         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fifo_in_ctrl_en  <= 1'b0;
      fifo_out_ctrl_en <= 1'b0;
      mem_rd_ctrl_en   <= 1'b0;
      w_offset_addr    <= '0;
      accum_acc        <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_row_q        <= num_row_d;
      num_tile_q       <= num_tile_d;
      acc_base_q       <= acc_base_d;
      prefetch_q       <= prefetch_d;
      tile_idx         <= tile_idx_d;
      busy             <= (state_d != S_IDLE);
      done             <= (state_q == S_DONE);
      fifo_in_ctrl_en  <= fill_d;
      fifo_out_ctrl_en <= fill_d;
      mem_rd_ctrl_en   <= mem_rd_d;
      w_offset_addr    <= w_offset_d;
      accum_acc        <= (tile_idx_d != '0);
    end
  end

  accum_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .num_row(num_row_q),
    .base   (acc_base_d),
    .addr   (accum_wr_addr)
  );

`ifdef TILE_COMPUTE_CTRL_PERF_EN
  // Busy-cycle counter, restarted by each accepted job, saturating.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_cycles <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
    end else if (state_q != S_IDLE && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_compute_ctrl.sv
// Bench for tile_compute_ctrl: directed and randomized jobs checked against a
// job-level reference model (expected fill offsets, row addresses, pulse
// counts and the latencies the controller promises).
module tb_tile_compute_ctrl;

  localparam int SYS_ROW = 16;
  localparam int TW      = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_row_in = '0;
  logic [TW-1:0] num_tile_in = '0;
  logic [15:0] acc_base_in = '0;
  logic        drain_done = 1'b0;
  logic        sys_done = 1'b0;
  logic        sys_en_out = 1'b0;
  logic        busy, done, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en;
  logic [15:0] w_offset_addr, accum_wr_addr;
  logic        accum_acc;
  logic [TW-1:0] tile_idx;
  logic [31:0] perf_cycles;

  int errors = 0;
  int checks = 0;

  // Event log filled by the monitor, read as deltas by the job tasks.
  int          mon_mem_rd = 0;
  int          mon_done = 0;
  int          mon_busy = 0;
  int          mon_fills = 0;
  int          mon_bad = 0;
  logic [15:0] fill_log [256];

  tile_compute_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .num_row_in(num_row_in),
    .num_tile_in(num_tile_in), .acc_base_in(acc_base_in),
    .drain_done(drain_done), .sys_done(sys_done), .sys_en_out(sys_en_out),
    .busy(busy), .done(done), .fifo_in_ctrl_en(fifo_in_ctrl_en),
    .fifo_out_ctrl_en(fifo_out_ctrl_en), .mem_rd_ctrl_en(mem_rd_ctrl_en),
    .w_offset_addr(w_offset_addr), .accum_wr_addr(accum_wr_addr),
    .accum_acc(accum_acc), .tile_idx(tile_idx), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_rd_ctrl_en) mon_mem_rd <= mon_mem_rd + 1;
    if (done) mon_done <= mon_done + 1;
    if (busy) mon_busy <= mon_busy + 1;
    if (fifo_in_ctrl_en) begin
      fill_log[mon_fills % 256] <= w_offset_addr;
      mon_fills <= mon_fills + 1;
    end
    if ((fifo_in_ctrl_en !== fifo_out_ctrl_en) || (!fifo_in_ctrl_en && w_offset_addr !== 16'h0))
      mon_bad <= mon_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int rows, input int tiles, input logic [15:0] base,
                         input logic [7:0] early, input int late_d, input bit poke_start,
                         input string tag);
    int mr0, dn0, bz0, fl0, bd0, extra, wait_len, exp_fills;
    logic [15:0] exp_addr, exp_off;
    logic [31:0] exp_perf;
    mr0 = mon_mem_rd; dn0 = mon_done; bz0 = mon_busy; fl0 = mon_fills; bd0 = mon_bad;
    num_row_in = 16'(rows); num_tile_in = TW'(tiles); acc_base_in = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    num_row_in = 16'($urandom); num_tile_in = TW'($urandom); acc_base_in = 16'($urandom);
    if (rows == 0 || tiles == 0) begin
      checks++;
      if ({busy, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, done} !== 5'b10000) begin
        errors++; $display("FAIL %s empty_accept: got %b expected 10000", tag,
                           {busy, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, done});
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b01) begin
        errors++; $display("FAIL %s empty_done: busy,done got %b expected 01", tag, {busy, done});
      end
      tick();
    end else begin
      checks++;
      if ({busy, fifo_in_ctrl_en, fifo_out_ctrl_en} !== 3'b111 || w_offset_addr !== 16'h0) begin
        errors++; $display("FAIL %s first_fill: got %b off %h expected 111 off 0000", tag,
                           {busy, fifo_in_ctrl_en, fifo_out_ctrl_en}, w_offset_addr);
      end
      repeat ($urandom_range(0, 3)) tick();
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      checks++;
      if (mem_rd_ctrl_en !== 1'b1) begin
        errors++; $display("FAIL %s first_mem_rd: got %b expected 1", tag, mem_rd_ctrl_en);
      end
      for (int t = 0; t < tiles; t++) begin
        checks++;
        if (tile_idx !== TW'(t) || accum_acc !== (t != 0)) begin
          errors++; $display("FAIL %s tile_state: tile_idx %0d acc %b expected %0d %b", tag,
                             tile_idx, accum_acc, t, (t != 0));
        end
        extra = $urandom_range(0, 2);
        for (int k = 0; k < rows + extra; k++) begin
          if ($urandom_range(0, 1) == 1) tick();
          exp_addr = base + 16'(k % rows);
          checks++;
          if (accum_wr_addr !== exp_addr) begin
            errors++; $display("FAIL %s addr t%0d r%0d: got %h expected %h", tag, t, k,
                               accum_wr_addr, exp_addr);
          end
          sys_en_out = 1'b1;
          if (poke_start && t == 0 && k == 0) start = 1'b1;
          if (early[t] && k == 0 && t + 1 < tiles) drain_done = 1'b1;
          tick();
          sys_en_out = 1'b0; start = 1'b0; drain_done = 1'b0;
        end
        sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        if (t == tiles - 1) begin
          checks++;
          if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL %s done_lat1: busy,done got %b expected 10", tag, {busy, done});
          end
          tick();
          checks++;
          if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL %s done_lat2: busy,done got %b expected 01", tag, {busy, done});
          end
          tick();
          checks++;
          if (done !== 1'b0) begin
            errors++; $display("FAIL %s done_width: got %b expected 0", tag, done);
          end
        end else begin
          wait_len = early[t] ? 1 : late_d;
          for (int w = 0; w < wait_len; w++) begin
            checks++;
            if (mem_rd_ctrl_en !== 1'b0 || busy !== 1'b1) begin
              errors++; $display("FAIL %s wait_w t%0d c%0d: mem_rd,busy got %b%b expected 01", tag,
                                 t, w, mem_rd_ctrl_en, busy);
            end
            if (w == wait_len - 1 && !early[t]) drain_done = 1'b1;
            tick();
            drain_done = 1'b0;
          end
          checks++;
          if (mem_rd_ctrl_en !== 1'b1) begin
            errors++; $display("FAIL %s wait_exit t%0d: mem_rd got %b expected 1", tag, t,
                               mem_rd_ctrl_en);
          end
        end
      end
    end
    exp_fills = (rows == 0 || tiles == 0) ? 0 : tiles;
    checks++;
    if (mon_mem_rd - mr0 !== exp_fills || mon_done - dn0 !== 1 || mon_fills - fl0 !== exp_fills) begin
      errors++; $display("FAIL %s counts: mem_rd %0d done %0d fills %0d expected %0d 1 %0d", tag,
                         mon_mem_rd - mr0, mon_done - dn0, mon_fills - fl0, exp_fills, exp_fills);
    end
    for (int i = 0; i < exp_fills; i++) begin
      exp_off = 16'(i * SYS_ROW);
      checks++;
      if (fill_log[(fl0 + i) % 256] !== exp_off) begin
        errors++; $display("FAIL %s fill_off %0d: got %h expected %h", tag, i,
                           fill_log[(fl0 + i) % 256], exp_off);
      end
    end
    checks++;
    if (mon_bad - bd0 !== 0) begin
      errors++; $display("FAIL %s fill_shape: got %0d bad cycles expected 0", tag, mon_bad - bd0);
    end
`ifdef TILE_COMPUTE_CTRL_PERF_EN
    exp_perf = 32'(mon_busy - bz0);
`else
    exp_perf = 32'd0;
`endif
    checks++;
    if (perf_cycles !== exp_perf) begin
      errors++; $display("FAIL %s perf: got %0d expected %0d", tag, perf_cycles, exp_perf);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, accum_acc} !== 6'b0 ||
        w_offset_addr !== 16'h0 || accum_wr_addr !== 16'h0 || tile_idx !== '0 || perf_cycles !== 32'h0) begin
      errors++; $display("FAIL reset_state: flags %b off %h addr %h tile %0d perf %0d expected all 0",
                         {busy, done, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, accum_acc},
                         w_offset_addr, accum_wr_addr, tile_idx, perf_cycles);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_tile();
    run_job(4, 1, 16'h0010, 8'h00, 1, 1'b0, "single");
  endtask

  task automatic test_three_tiles();
    run_job(4, 3, 16'h0100, 8'h01, 5, 1'b0, "three");
  endtask

  task automatic test_empty_jobs();
    run_job(0, 3, 16'h0020, 8'h00, 1, 1'b0, "zero_rows");
    run_job(5, 0, 16'h0030, 8'h00, 1, 1'b0, "zero_tiles");
  endtask

  task automatic test_start_while_busy();
    run_job(3, 2, 16'h0200, 8'h00, 2, 1'b1, "start_busy");
  endtask

  task automatic test_abort();
    int dn0;
    dn0 = mon_done;
    num_row_in = 16'd3; num_tile_in = TW'(2); acc_base_in = 16'h0300;
    start = 1'b1; tick(); start = 1'b0;
    drain_done = 1'b1; tick(); drain_done = 1'b0;
    sys_en_out = 1'b1; tick(); sys_en_out = 1'b0;
    sys_done = 1'b1; tick(); sys_done = 1'b0;
    drain_done = 1'b1; tick(); drain_done = 1'b0;
    sys_en_out = 1'b1; tick(); sys_en_out = 1'b0;
    checks++;
    if ({busy, accum_acc} !== 2'b11 || tile_idx !== TW'(1) || accum_wr_addr !== 16'h0301) begin
      errors++; $display("FAIL abort_pre: busy,acc %b tile %0d addr %h expected 11 1 0301",
                         {busy, accum_acc}, tile_idx, accum_wr_addr);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({busy, done, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, accum_acc} !== 6'b0 ||
        w_offset_addr !== 16'h0 || accum_wr_addr !== 16'h0 || tile_idx !== '0 || perf_cycles !== 32'h0) begin
      errors++; $display("FAIL abort_reset: flags %b off %h addr %h tile %0d expected all 0",
                         {busy, done, fifo_in_ctrl_en, fifo_out_ctrl_en, mem_rd_ctrl_en, accum_acc},
                         w_offset_addr, accum_wr_addr, tile_idx);
    end
    rstn = 1'b1;
    repeat (3) tick();
    checks++;
    if (mon_done - dn0 !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done pulses %0d busy %b expected 0 0", mon_done - dn0, busy);
    end
    run_job(2, 2, 16'h0400, 8'h03, 1, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 10), $urandom_range(1, 8),
              (j % 3 == 0) ? 16'hFFFA : 16'($urandom), 8'($urandom),
              $urandom_range(1, 6), (j % 2 == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_three_tiles();
    test_empty_jobs();
    test_start_while_busy();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
